// File: rtl/fm0_backscatter_tx.sv
// FM0 backscatter transmitter: pops tag-response bytes from the FIFO read port and
// sends preamble, MSB-first FM0 data and a closing dummy data-1 to the modulator.
//
// state   | meaning
// S_IDLE  | waiting for start with a non-empty FIFO; tx_out parked at 0
// S_PRE   | sending the fixed preamble, one level per half-symbol
// S_DATA  | FM0 data bits; next byte prefetched on the first clock of bit 0
// S_DUMMY | closing data-1, then back to idle with a done pulse
module fm0_backscatter_tx #(
    parameter int unsigned        HALF_CYCLES = 4,
    parameter int unsigned        PRE_LEN     = 12,
    parameter logic [PRE_LEN-1:0] PREAMBLE    = 12'b110100100011,
    parameter int unsigned        CNT_W       = 8
) (
    input  logic       r_clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       start,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);
    localparam int unsigned       PW      = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
    localparam logic [CNT_W-1:0] HC_TOP  = CNT_W'(HALF_CYCLES - 1);
    localparam logic [PW-1:0]    PRE_TOP = PW'(PRE_LEN - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRE = 2'd1, S_DATA = 2'd2, S_DUMMY = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hc_q, hc_d;
    logic             half_q, half_d;
    logic [2:0]       bit_q, bit_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             pop_q, pop_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hc_tc;
    logic             rd_c;
    logic [PW-1:0]    pre_nxt;

    assign hc_tc   = (hc_q == '0);
    assign pre_nxt = pre_q - PW'(1);

    always_ff @(posedge r_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            hc_q         <= '0;
            half_q       <= 1'b0;
            bit_q        <= 3'd0;
            pre_q        <= '0;
            shift_q      <= 8'h00;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            pop_q        <= 1'b0;
            tx_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hc_q         <= hc_d;
            half_q       <= half_d;
            bit_q        <= bit_d;
            pre_q        <= pre_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            pop_q        <= pop_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hc_d         = hc_q;
        half_d       = half_q;
        bit_d        = bit_q;
        pre_d        = pre_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        pop_d        = pop_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        done_d       = done_q;
        if (en) begin
            pop_d  = rd_c;
            done_d = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start && !fifo_empty) begin
                        state_d      = S_PRE;
                        busy_d       = 1'b1;
                        tx_d         = PREAMBLE[PRE_LEN-1];
                        pre_d        = PRE_TOP;
                        hc_d         = HC_TOP;
                        hold_valid_d = 1'b0;
                    end
                end
                S_PRE: begin
                    if (pop_q) shift_d = fifo_data;
                    if (hc_tc) begin
                        hc_d = HC_TOP;
                        if (pre_q == '0) begin
                            state_d = S_DATA;
                            tx_d    = ~tx_q;
                            half_d  = 1'b0;
                            bit_d   = 3'd7;
                        end else begin
                            pre_d = pre_nxt;
                            tx_d  = PREAMBLE[pre_nxt];
                        end
                    end else begin
                        hc_d = hc_q - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (pop_q) begin
                        hold_d       = fifo_data;
                        hold_valid_d = 1'b1;
                    end
                    if (hc_tc) begin
                        hc_d = HC_TOP;
                        if (!half_q) begin
                            half_d = 1'b1;
                            if (!shift_q[7]) tx_d = ~tx_q;
                        end else begin
                            half_d = 1'b0;
                            tx_d   = ~tx_q;
                            bit_d  = bit_q - 3'd1;
                            // bit 0 done: chain straight into the prefetched byte if there is one
                            if (bit_q == 3'd0) begin
                                if (hold_valid_q) begin
                                    shift_d      = hold_q;
                                    hold_valid_d = 1'b0;
                                end else begin
                                    state_d = S_DUMMY;
                                end
                            end else begin
                                shift_d = {shift_q[6:0], 1'b0};
                            end
                        end
                    end else begin
                        hc_d = hc_q - CNT_W'(1);
                    end
                end
                S_DUMMY: begin
                    if (hc_tc) begin
                        hc_d = HC_TOP;
                        if (!half_q) begin
                            half_d = 1'b1;
                        end else begin
                            half_d  = 1'b0;
                            state_d = S_IDLE;
                            tx_d    = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        hc_d = hc_q - CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The pop strobe must land in the same cycle as start, so it is decoded, not registered.
    always_comb begin
        rd_c = reset_n && en && !fifo_empty &&
               (((state_q == S_IDLE) && start) ||
                ((state_q == S_DATA) && (bit_q == 3'd0) && !half_q && (hc_q == HC_TOP)));
        fifo_read = rd_c;
        tx_out    = tx_q;
        busy      = busy_q;
        done      = done_q;
    end
endmodule

// File: tb/tb_fm0_backscatter_tx.sv
// Bench for fm0_backscatter_tx: FIFO model plus a half-symbol level model built from
// the FM0 rules, checked every cycle, and literal waveforms for the directed frames.
module tb_fm0_backscatter_tx;
    localparam int H  = 2;
    localparam int PL = 12;
    localparam logic [11:0] PRE = 12'b110100100011;
    localparam logic [63:0] EXP_A5 = 64'(30'b110100100011_0010110101001011_00);
    localparam logic [63:0] EXP_00FF = 64'(46'b110100100011_0101010101010101_0011001100110011_00);
    localparam logic [63:0] EXP_55 = 64'(30'b110100100011_0100101101001011_00);

    logic r_clk = 1'b0, reset_n = 1'b0, en = 1'b0, start = 1'b0;
    logic fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic fifo_read, tx_out, busy, done;

    logic push_req = 1'b0;
    logic [7:0] push_val = 8'h00;
    logic [7:0] fq[$];
    bit   lv[$];
    logic trace[$];
    bit   m_busy = 0, m_done = 0, chk_on = 0;
    int   m_k = 0, m_nbytes = 0;
    int   n_cmp = 0, n_bad = 0;

    fm0_backscatter_tx #(.HALF_CYCLES(H), .PRE_LEN(PL), .PREAMBLE(PRE), .CNT_W(8)) dut (
        .r_clk(r_clk), .reset_n(reset_n), .en(en), .start(start),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(fifo_read),
        .tx_out(tx_out), .busy(busy), .done(done));

    always #5 r_clk = ~r_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void append_byte(input logic [7:0] b);
        bit l;
        for (int i = 7; i >= 0; i--) begin
            l = !lv[$];
            lv.push_back(l);
            lv.push_back(b[i] ? l : !l);
        end
    endfunction

    function automatic bit at_prefetch();
        int kk;
        kk = m_k - PL * H;
        if (kk < 0 || kk >= 16 * H * m_nbytes) return 0;
        return (kk % (16 * H)) == 14 * H;
    endfunction

    function automatic bit exp_read();
        if (!reset_n || !en || fifo_empty) return 0;
        if (!m_busy) return start;
        return at_prefetch();
    endfunction

    function automatic bit exp_tx();
        if (m_busy && (m_k / H) < lv.size()) return lv[m_k / H];
        return 0;
    endfunction

    function automatic void model_step();
        bit pop_e;
        bit l;
        pop_e = exp_read();
        if (!m_busy) begin
            m_done = 0;
            if (pop_e) begin
                lv.delete();
                for (int i = PL - 1; i >= 0; i--) lv.push_back(PRE[i]);
                append_byte(fq[0]);
                m_nbytes = 1;
                m_busy = 1;
                m_k = 0;
            end
        end else begin
            if (pop_e) begin
                append_byte(fq[0]);
                m_nbytes++;
            end else if (at_prefetch()) begin
                l = !lv[$];
                lv.push_back(l);
                lv.push_back(l);
            end
            m_k++;
            if (m_k == lv.size() * H) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    endfunction

    always @(posedge r_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0;
            m_done = 0;
            m_k = 0;
        end else begin
            if (en) model_step();
            if (push_req) fq.push_back(push_val);
            if (fifo_read && fq.size() > 0) fifo_data <= fq.pop_front();
            fifo_empty <= (fq.size() == 0);
        end
    end

    always @(negedge r_clk) begin
        if (chk_on) begin
            chk("tx_out", tx_out, exp_tx());
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("fifo_read", fifo_read, exp_read());
        end
    end

    function automatic logic [63:0] wave_vec(input int skip_lo, input int skip_n);
        logic [63:0] v;
        int j;
        v = '0;
        j = 0;
        for (int i = 0; i < trace.size(); i++) begin
            if (!(i >= skip_lo && i < skip_lo + skip_n)) begin
                if (j % H == 0) v = {v[62:0], trace[i]};
                j++;
            end
        end
        return v;
    endfunction

    function automatic logic [63:0] model_vec();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < lv.size(); i++) v = {v[62:0], lv[i]};
        return v;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        push_req = 1'b1;
        push_val = b;
        @(posedge r_clk); #1;
        push_req = 1'b0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(negedge r_clk);
        chk("start_pop", fifo_read, 1);
        @(posedge r_clk); #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input int frz_at, input int frz_len, input int push_at,
                             input logic [7:0] pv, input int rst_at,
                             output int len, output int reads, output int read_pos);
        int n;
        n = 0;
        reads = 0;
        read_pos = -1;
        trace.delete();
        forever begin
            @(negedge r_clk);
            if (done) break;
            trace.push_back(tx_out);
            if (fifo_read) begin
                reads++;
                read_pos = n;
            end
            n++;
            if (n > 400) begin
                n_cmp++;
                n_bad++;
                $display("FAIL frame_timeout: no done after %0d cycles", n);
                break;
            end
            @(posedge r_clk); #1;
            en = !(frz_len > 0 && n >= frz_at && n < frz_at + frz_len);
            push_req = (n == push_at - 1);
            push_val = pv;
            if (n == rst_at) begin
                #2 reset_n = 1'b0;
                break;
            end
        end
        len = n;
        push_req = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        int len, reads, rpos, cnt_r, cnt_b;
        reset_n = 1'b0;
        en = 1'b1;
        repeat (2) @(negedge r_clk);
        chk("rst_tx", tx_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_read", fifo_read, 0);
        @(posedge r_clk); #1;
        reset_n = 1'b1;
        chk_on = 1;
        repeat (2) begin @(posedge r_clk); #1; end

        // single byte 0xA5
        push_byte(8'hA5);
        start_frame();
        run_frame(0, 0, -1, 8'h00, -1, len, reads, rpos);
        chk("a5_len", len, 60);
        chk("a5_done_tx", tx_out, 0);
        chk("a5_done_busy", busy, 0);
        chk("a5_reads", reads, 0);
        chk("a5_wave", wave_vec(0, 0), EXP_A5);
        chk("a5_model", model_vec(), EXP_A5);
        repeat (3) begin @(posedge r_clk); #1; end

        // two bytes 0x00, 0xFF chained with no gap
        push_byte(8'h00);
        push_byte(8'hFF);
        start_frame();
        run_frame(0, 0, -1, 8'h00, -1, len, reads, rpos);
        chk("two_len", len, 92);
        chk("two_reads", reads, 1);
        chk("two_read_pos", rpos, 52);
        chk("two_wave", wave_vec(0, 0), EXP_00FF);
        chk("two_model", model_vec(), EXP_00FF);
        repeat (3) begin @(posedge r_clk); #1; end

        // start with an empty FIFO is ignored
        cnt_r = 0;
        cnt_b = 0;
        start = 1'b1;
        repeat (8) begin
            @(negedge r_clk);
            if (fifo_read) cnt_r++;
            if (busy) cnt_b++;
            @(posedge r_clk); #1;
        end
        start = 1'b0;
        chk("empty_reads", cnt_r, 0);
        chk("empty_busy", cnt_b, 0);
        chk("empty_tx", tx_out, 0);

        // FIFO refilled one clock after byte 1's prefetch point
        push_byte(8'h3C);
        push_byte(8'h81);
        start_frame();
        run_frame(0, 0, 85, 8'h55, -1, len, reads, rpos);
        chk("late_len", len, 92);
        chk("late_reads", reads, 1);
        chk("late_read_pos", rpos, 52);
        chk("late_fifo_left", fq.size(), 1);
        chk("late_fifo_byte", fq[0], 8'h55);
        repeat (3) begin @(posedge r_clk); #1; end

        // en low for 5 cycles mid-DATA, using the leftover 0x55
        start_frame();
        run_frame(40, 5, -1, 8'h00, -1, len, reads, rpos);
        chk("frz_len", len, 65);
        cnt_r = 0;
        for (int i = 41; i <= 45; i++) if (trace[i] !== trace[40]) cnt_r++;
        chk("frz_hold", cnt_r, 0);
        chk("frz_wave", wave_vec(41, 5), EXP_55);
        repeat (3) begin @(posedge r_clk); #1; end

        // reset mid-DATA aborts, next frame is clean
        push_byte(8'h96);
        start_frame();
        run_frame(0, 0, -1, 8'h00, 40, len, reads, rpos);
        #1;
        chk("arst_tx", tx_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_read", fifo_read, 0);
        @(posedge r_clk); #3;
        reset_n = 1'b1;
        cnt_r = 0;
        repeat (20) begin
            @(negedge r_clk);
            if (done) cnt_r++;
        end
        chk("arst_no_done", cnt_r, 0);
        @(posedge r_clk); #1;
        push_byte(8'hA5);
        start_frame();
        run_frame(0, 0, -1, 8'h00, -1, len, reads, rpos);
        chk("post_rst_len", len, 60);
        chk("post_rst_wave", wave_vec(0, 0), EXP_A5);
        repeat (3) begin @(posedge r_clk); #1; end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
